// File: rtl/mc_port_arb.sv
// mc_port_arb: round-robin arbiter funnelling NUM_REQ upstream request ports into one
// memory-controller request port, and steering MC responses back to their requesters by
// the ID carried in the top IDW bits of rtnctl.
// Optional build macro: MC_ARB_PERF_EN adds per-requester grant counters and an MC stall
// cycle counter. When it is undefined, both perf outputs are tied to zero and no counter
// logic is built.
module mc_port_arb #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned RTNCTL_WIDTH = 32,
  localparam int unsigned IDW = $clog2(NUM_REQ),
  localparam int unsigned RCW = RTNCTL_WIDTH - IDW,
  localparam int unsigned RQW = 3 + 4 + 2 + 48 + 64 + RCW,
  localparam int unsigned RSW = 3 + 4 + 64 + RCW
) (
  input  logic                      clk,
  input  logic                      i_reset,
  // upstream request ports
  input  logic [NUM_REQ-1:0]        rq_vld,
  input  logic [NUM_REQ*RQW-1:0]    rq_pkt,
  output logic [NUM_REQ-1:0]        rq_stall,
  // MC request port
  output logic                      mc_rq_vld,
  output logic [2:0]                mc_rq_cmd,
  output logic [3:0]                mc_rq_scmd,
  output logic [1:0]                mc_rq_size,
  output logic [47:0]               mc_rq_vadr,
  output logic [63:0]               mc_rq_data,
  output logic [RTNCTL_WIDTH-1:0]   mc_rq_rtnctl,
  input  logic                      mc_rq_stall,
  // MC response port
  input  logic                      mc_rs_vld,
  input  logic [2:0]                mc_rs_cmd,
  input  logic [3:0]                mc_rs_scmd,
  input  logic [63:0]               mc_rs_data,
  input  logic [RTNCTL_WIDTH-1:0]   mc_rs_rtnctl,
  output logic                      mc_rs_stall,
  // upstream response ports
  output logic [NUM_REQ-1:0]        rs_vld,
  output logic [RSW-1:0]            rs_pkt,
  input  logic [NUM_REQ-1:0]        rs_stall,
  // performance counters
  output logic [NUM_REQ*32-1:0]     perf_grants,
  output logic [31:0]               perf_stall_cyc
);

  // ---------------------------------------------------------------------------
  // Request path: output slot state
  // ---------------------------------------------------------------------------
  logic               r_slot_vld;
  logic [2:0]         r_cmd;
  logic [3:0]         r_scmd;
  logic [1:0]         r_size;
  logic [47:0]        r_vadr;
  logic [63:0]        r_data;
  logic [IDW-1:0]     r_id;
  logic [RCW-1:0]     r_rtnctl;
  logic [IDW-1:0]     r_last_grant;

  logic               w_loadable;
  logic               w_drain;
  logic               w_gnt_vld;
  logic [IDW-1:0]     w_gnt_idx;
  logic [IDW-1:0]     w_cand;
  logic               w_grant;
  logic [RQW-1:0]     w_sel_pkt;

  // Slot can take a new request when empty or when its current content leaves this cycle.
  assign w_drain    = r_slot_vld && !mc_rq_stall;
  assign w_loadable = !r_slot_vld || !mc_rq_stall;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      // IDW-bit add wraps naturally because NUM_REQ is a power of two
      w_cand = r_last_grant + IDW'(k);
      if (!w_gnt_vld && rq_vld[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
  end

  assign w_grant   = w_loadable && w_gnt_vld && !i_reset;
  assign w_sel_pkt = rq_pkt[w_gnt_idx*RQW +: RQW];

  // Back-pressure: only the requester granted this cycle sees its stall released.
  always_comb begin
    rq_stall = '1;
    if (w_grant) begin
      rq_stall[w_gnt_idx] = 1'b0;
    end
  end

  // Output slot: load on grant, empty on drain, otherwise hold (covers the stalled case).
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_slot_vld <= 1'b0;
      r_cmd      <= '0;
      r_scmd     <= '0;
      r_size     <= '0;
      r_vadr     <= '0;
      r_data     <= '0;
      r_id       <= '0;
      r_rtnctl   <= '0;
    end else if (w_grant) begin
      r_slot_vld <= 1'b1;
      r_cmd      <= w_sel_pkt[RQW-1 -: 3];
      r_scmd     <= w_sel_pkt[RQW-4 -: 4];
      r_size     <= w_sel_pkt[RQW-8 -: 2];
      r_vadr     <= w_sel_pkt[RQW-10 -: 48];
      r_data     <= w_sel_pkt[RCW+63 : RCW];
      r_id       <= w_gnt_idx;
      r_rtnctl   <= w_sel_pkt[RCW-1:0];
    end else if (w_drain) begin
      r_slot_vld <= 1'b0;
    end
  end

  // Last-grant pointer; reset value makes requester 0 the first in line.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_last_grant <= IDW'(NUM_REQ - 1);
    end else if (w_grant) begin
      r_last_grant <= w_gnt_idx;
    end
  end

  assign mc_rq_vld    = r_slot_vld;
  assign mc_rq_cmd    = r_cmd;
  assign mc_rq_scmd   = r_scmd;
  assign mc_rq_size   = r_size;
  assign mc_rq_vadr   = r_vadr;
  assign mc_rq_data   = r_data;
  // ID field comes from the arbiter, so a requester cannot spoof another's responses
  assign mc_rq_rtnctl = {r_id, r_rtnctl};

  // ---------------------------------------------------------------------------
  // Response path: independent of the request path
  // ---------------------------------------------------------------------------
  logic [NUM_REQ-1:0] r_rs_vld;
  logic [RSW-1:0]     r_rs_pkt;
  logic [IDW-1:0]     w_rs_id;

  assign w_rs_id     = mc_rs_rtnctl[RTNCTL_WIDTH-1 -: IDW];
  // Any stalled requester stalls the MC; in-flight skid responses are still forwarded.
  assign mc_rs_stall = |rs_stall;

  // Register the response and steer valid to the requester named in the ID field.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_rs_vld <= '0;
      r_rs_pkt <= '0;
    end else begin
      r_rs_vld <= mc_rs_vld ? (NUM_REQ'(1) << w_rs_id) : '0;
      if (mc_rs_vld) begin
        r_rs_pkt <= {mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl[RCW-1:0]};
      end
    end
  end

  assign rs_vld = r_rs_vld;
  assign rs_pkt = r_rs_pkt;

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef MC_ARB_PERF_EN
  logic [NUM_REQ*32-1:0] r_perf_grants;
  logic [31:0]           r_perf_stall_cyc;

  // Count accepted requests per requester and MC-stalled cycles; both wrap at 2^32.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      r_perf_grants    <= '0;
      r_perf_stall_cyc <= '0;
    end else begin
      if (w_grant) begin
        r_perf_grants[w_gnt_idx*32 +: 32] <= r_perf_grants[w_gnt_idx*32 +: 32] + 32'd1;
      end
      if (r_slot_vld && mc_rq_stall) begin
        r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      end
    end
  end

  assign perf_grants    = r_perf_grants;
  assign perf_stall_cyc = r_perf_stall_cyc;
`else
  assign perf_grants    = '0;
  assign perf_stall_cyc = '0;
`endif

endmodule

// File: tb/tb_mc_port_arb.sv
// tb_mc_port_arb: randomized and directed stimulus for mc_port_arb with a scoreboard.
// The stimulus process runs a behavioural round-robin model and pushes expected MC
// requests and upstream responses into queues; a monitor pops and compares whenever the
// DUT presents a transfer.
module tb_mc_port_arb;

  localparam int N   = 4;
  localparam int RW  = 32;
  localparam int IDW = 2;
  localparam int RCW = RW - IDW;
  localparam int RQW = 121 + RCW;
  localparam int RSW = 71 + RCW;
  localparam int MQW = RQW + IDW;

  logic               clk;
  logic               i_reset;
  logic [N-1:0]       rq_vld;
  logic [N*RQW-1:0]   rq_pkt;
  logic [N-1:0]       rq_stall;
  logic               mc_rq_vld;
  logic [2:0]         mc_rq_cmd;
  logic [3:0]         mc_rq_scmd;
  logic [1:0]         mc_rq_size;
  logic [47:0]        mc_rq_vadr;
  logic [63:0]        mc_rq_data;
  logic [RW-1:0]      mc_rq_rtnctl;
  logic               mc_rq_stall;
  logic               mc_rs_vld;
  logic [2:0]         mc_rs_cmd;
  logic [3:0]         mc_rs_scmd;
  logic [63:0]        mc_rs_data;
  logic [RW-1:0]      mc_rs_rtnctl;
  logic               mc_rs_stall;
  logic [N-1:0]       rs_vld;
  logic [RSW-1:0]     rs_pkt;
  logic [N-1:0]       rs_stall;
  logic [N*32-1:0]    perf_grants;
  logic [31:0]        perf_stall_cyc;

  mc_port_arb #(
    .NUM_REQ      (N),
    .RTNCTL_WIDTH (RW)
  ) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .rq_vld         (rq_vld),
    .rq_pkt         (rq_pkt),
    .rq_stall       (rq_stall),
    .mc_rq_vld      (mc_rq_vld),
    .mc_rq_cmd      (mc_rq_cmd),
    .mc_rq_scmd     (mc_rq_scmd),
    .mc_rq_size     (mc_rq_size),
    .mc_rq_vadr     (mc_rq_vadr),
    .mc_rq_data     (mc_rq_data),
    .mc_rq_rtnctl   (mc_rq_rtnctl),
    .mc_rq_stall    (mc_rq_stall),
    .mc_rs_vld      (mc_rs_vld),
    .mc_rs_cmd      (mc_rs_cmd),
    .mc_rs_scmd     (mc_rs_scmd),
    .mc_rs_data     (mc_rs_data),
    .mc_rs_rtnctl   (mc_rs_rtnctl),
    .mc_rs_stall    (mc_rs_stall),
    .rs_vld         (rs_vld),
    .rs_pkt         (rs_pkt),
    .rs_stall       (rs_stall),
    .perf_grants    (perf_grants),
    .perf_stall_cyc (perf_stall_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Scoreboard queues
  logic [MQW-1:0]     exp_rq_q[$];
  logic [N+RSW-1:0]   exp_rs_q[$];

  // Reference model state
  int    m_last;
  bit    m_occ;
  bit    m_rs_prev;
  int    m_grants[N];
  int    m_stall_cyc;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  function automatic logic [RQW-1:0] rand_pkt();
    return {3'($urandom), 4'($urandom), 2'($urandom), 48'({$urandom, $urandom}),
            64'({$urandom, $urandom}), RCW'($urandom)};
  endfunction

  task automatic model_reset();
    m_last      = N - 1;
    m_occ       = 1'b0;
    m_rs_prev   = 1'b0;
    m_stall_cyc = 0;
    for (int i = 0; i < N; i++) m_grants[i] = 0;
    exp_rq_q.delete();
    exp_rs_q.delete();
  endtask

  // One clock cycle: check combinational outputs and step the model at the negedge,
  // then return just after the next rising edge so the caller can drive new inputs.
  task automatic tick();
    int             g;
    logic [N-1:0]   want_stall;
    logic [N-1:0]   oh;
    logic [RQW-1:0] pkt;
    bit             loadable;
    @(negedge clk);
    chk("mc_rq_vld", mc_rq_vld, m_occ);
    chk("mc_rs_stall", mc_rs_stall, |rs_stall);
    chk("rs_vld_any", |rs_vld, m_rs_prev);
    loadable = !m_occ || !mc_rq_stall;
    g = -1;
    if (loadable) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (g < 0 && rq_vld[idx]) g = idx;
      end
    end
    want_stall = '1;
    if (g >= 0) want_stall[g] = 1'b0;
    chk("rq_stall", rq_stall, want_stall);
    if (m_occ && mc_rq_stall) m_stall_cyc++;
    if (g >= 0) begin
      pkt = rq_pkt[g*RQW +: RQW];
      exp_rq_q.push_back({pkt[RQW-1:RCW], IDW'(g), pkt[RCW-1:0]});
      m_last = g;
      m_grants[g]++;
      m_occ = 1'b1;
    end else if (!mc_rq_stall) begin
      m_occ = 1'b0;
    end
    if (mc_rs_vld) begin
      oh = '0;
      oh[mc_rs_rtnctl[RW-1 -: IDW]] = 1'b1;
      exp_rs_q.push_back({oh, mc_rs_cmd, mc_rs_scmd, mc_rs_data, mc_rs_rtnctl[RCW-1:0]});
    end
    m_rs_prev = mc_rs_vld;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every downstream request transfer and every upstream response.
  always @(negedge clk) begin
    if (!i_reset && mc_rq_vld && !mc_rq_stall) begin
      if (exp_rq_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL mc_rq_unexpected actual=%0h required=none",
                 {mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl});
      end else begin
        chk("mc_rq_pkt",
            {mc_rq_cmd, mc_rq_scmd, mc_rq_size, mc_rq_vadr, mc_rq_data, mc_rq_rtnctl},
            exp_rq_q.pop_front());
      end
    end
    if (!i_reset && rs_vld != '0) begin
      if (exp_rs_q.size() == 0) begin
        n_total++;
        n_bad++;
        $display("FAIL rs_unexpected actual=%0h required=none", {rs_vld, rs_pkt});
      end else begin
        chk("rs_resp", {rs_vld, rs_pkt}, exp_rs_q.pop_front());
      end
    end
  end

  task automatic randomize_rq_pkts();
    for (int i = 0; i < N; i++) rq_pkt[i*RQW +: RQW] = rand_pkt();
  endtask

  logic [N*32-1:0] want_perf;

  initial begin
    i_reset      = 1'b1;
    rq_vld       = '0;
    rq_pkt       = '0;
    mc_rq_stall  = 1'b0;
    mc_rs_vld    = 1'b0;
    mc_rs_cmd    = '0;
    mc_rs_scmd   = '0;
    mc_rs_data   = '0;
    mc_rs_rtnctl = '0;
    rs_stall     = '0;
    model_reset();
    #2;
    chk("rst_rq_stall", rq_stall, {N{1'b1}});
    chk("rst_mc_rq_vld", mc_rq_vld, 1'b0);
    chk("rst_rs_vld", rs_vld, '0);
    chk("rst_rs_pkt", rs_pkt, '0);
    chk("rst_perf_grants", perf_grants, '0);
    chk("rst_perf_stall", perf_stall_cyc, '0);
    repeat (2) @(posedge clk);
    #1;
    i_reset = 1'b0;

    // All requesters busy, no MC stall: grants rotate 0,1,2,3,... one per cycle.
    rq_vld = '1;
    for (int c = 0; c < 8; c++) begin
      randomize_rq_pkts();
      tick();
    end

    // Load a request with vadr 0x1000 from requester 0, then stall the MC for 5 cycles.
    rq_vld = 4'b0001;
    randomize_rq_pkts();
    rq_pkt[RQW-10 -: 48] = 48'h1000;
    tick();
    rq_vld      = '1;
    mc_rq_stall = 1'b1;
    for (int c = 0; c < 5; c++) begin
      randomize_rq_pkts();
      tick();
      chk("hold_vld", mc_rq_vld, 1'b1);
      chk("hold_vadr", mc_rq_vadr, 48'h1000);
    end
`ifdef MC_ARB_PERF_EN
    chk("perf_stall_5", perf_stall_cyc, 32'd5);
`else
    chk("perf_stall_off", perf_stall_cyc, 32'd0);
`endif
    mc_rq_stall = 1'b0;
    rq_vld      = '0;
    tick();

    // Response steered by ID field 2.
    mc_rs_vld    = 1'b1;
    mc_rs_cmd    = 3'd5;
    mc_rs_scmd   = 4'd9;
    mc_rs_data   = 64'hDEAD;
    mc_rs_rtnctl = 32'h8000_0ABC;
    tick();
    mc_rs_vld = 1'b0;
    chk("rs_dir_vld", rs_vld, 4'b0100);
    chk("rs_dir_rtnctl", rs_pkt[RCW-1:0], 30'h0ABC);
    chk("rs_dir_data", rs_pkt[RCW+63:RCW], 64'hDEAD);
    tick();

    // Requester 1 stalls responses; two skid responses for requester 3 still arrive.
    rs_stall = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      mc_rs_vld    = 1'b1;
      mc_rs_data   = 64'(c + 1);
      mc_rs_rtnctl = {2'd3, RCW'($urandom)};
      tick();
    end
    mc_rs_vld = 1'b0;
    rs_stall  = '0;
    tick();

    // Random traffic on both paths.
    for (int c = 0; c < 1500; c++) begin
      rq_vld       = N'($urandom);
      randomize_rq_pkts();
      mc_rq_stall  = ($urandom_range(0, 2) == 0);
      mc_rs_vld    = $urandom_range(0, 1) == 1;
      mc_rs_cmd    = 3'($urandom);
      mc_rs_scmd   = 4'($urandom);
      mc_rs_data   = 64'({$urandom, $urandom});
      mc_rs_rtnctl = $urandom;
      rs_stall     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      tick();
    end

    // Perf counters against the model (zero when the feature is compiled out).
`ifdef MC_ARB_PERF_EN
    for (int i = 0; i < N; i++) want_perf[i*32 +: 32] = 32'(m_grants[i]);
    chk("perf_grants", perf_grants, want_perf);
    chk("perf_stall_cyc", perf_stall_cyc, 32'(m_stall_cyc));
`else
    want_perf = '0;
    chk("perf_grants_off", perf_grants, want_perf);
    chk("perf_stall_off2", perf_stall_cyc, 32'd0);
`endif

    // Reset pulsed between edges while the slot is held by a stalled MC.
    mc_rs_vld   = 1'b0;
    rs_stall    = '0;
    rq_vld      = '1;
    mc_rq_stall = 1'b0;
    randomize_rq_pkts();
    tick();
    mc_rq_stall = 1'b1;
    tick();
    chk("pre_rst_vld", mc_rq_vld, 1'b1);
    #1 i_reset = 1'b1;
    #1;
    chk("midrst_mc_rq_vld", mc_rq_vld, 1'b0);
    chk("midrst_rq_stall", rq_stall, {N{1'b1}});
    chk("midrst_rs_vld", rs_vld, '0);
    chk("midrst_perf", perf_stall_cyc, 32'd0);
    i_reset = 1'b0;
    model_reset();
    rq_vld      = 4'b0100;
    mc_rq_stall = 1'b0;
    randomize_rq_pkts();
    tick();
    chk("post_rst_vld", mc_rq_vld, 1'b1);
    chk("post_rst_id", mc_rq_rtnctl[RW-1 -: IDW], 2'd2);

    // Drain and confirm nothing is left outstanding.
    rq_vld = '0;
    repeat (4) tick();
    chk("rq_queue_empty", exp_rq_q.size(), 0);
    chk("rs_queue_empty", exp_rs_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_port_arb.md
MC_PORT_ARB -- requirements
Module: mc_port_arb

Interface
REQ-001 Parameter NUM_REQ, default 4, number of upstream requesters; SHALL be a power of two, 2..16.
REQ-002 Parameter RTNCTL_WIDTH, default 32, MC rtnctl width; IDW = log2(NUM_REQ).
REQ-003 Request packet RQW = 3+4+2+48+64+(RTNCTL_WIDTH-IDW) bits, ordered {cmd,scmd,size,vadr,data,rtnctl}, MSB first.
REQ-004 Response packet RSW = 3+4+64+(RTNCTL_WIDTH-IDW) bits, ordered {cmd,scmd,data,rtnctl}, MSB first.
REQ-005 Ports SHALL be:
  clk  in  1  sole clock, all state on rising edge
  i_reset  in  1  asynchronous, active-high reset
  rq_vld  in  NUM_REQ  per-requester request valid
  rq_pkt  in  NUM_REQ*RQW  per-requester request packet
  rq_stall  out  NUM_REQ  per-requester back-pressure
  mc_rq_vld  out  1  MC request valid
  mc_rq_cmd  out  3  MC command
  mc_rq_scmd  out  4  MC sub-command
  mc_rq_size  out  2  MC size
  mc_rq_vadr  out  48  MC virtual address
  mc_rq_data  out  64  MC write data
  mc_rq_rtnctl  out  RTNCTL_WIDTH  {requester ID, requester rtnctl}
  mc_rq_stall  in  1  MC back-pressure
  mc_rs_vld  in  1  MC response valid
  mc_rs_cmd  in  3  response command
  mc_rs_scmd  in  4  response sub-command
  mc_rs_data  in  64  response data
  mc_rs_rtnctl  in  RTNCTL_WIDTH  response rtnctl
  mc_rs_stall  out  1  response back-pressure to MC
  rs_vld  out  NUM_REQ  per-requester response valid
  rs_pkt  out  RSW  response packet, shared by all requesters
  rs_stall  in  NUM_REQ  per-requester response back-pressure
  perf_grants  out  NUM_REQ*32  per-requester accepted-request counters
  perf_stall_cyc  out  32  cycles with mc_rq_vld && mc_rq_stall

Function
REQ-006 Request transfer upstream SHALL occur when rq_vld[i] && !rq_stall[i]; downstream when mc_rq_vld && !mc_rq_stall.
REQ-007 One registered output slot drives all mc_rq_* outputs; while mc_rq_vld && mc_rq_stall the slot and all mc_rq_* SHALL hold unchanged.
REQ-008 Slot is loadable when empty or draining in the same cycle; at most one grant per cycle, only when loadable.
REQ-009 Grant SHALL be round-robin: search starts at (last_grant+1) mod NUM_REQ; after reset last_grant = NUM_REQ-1, so requester 0 has top priority.
REQ-010 rq_stall[i] SHALL be 0 only for the granted requester in that cycle (combinational from rq_vld, slot state, mc_rq_stall).
REQ-011 Request latency: granted in cycle N -> mc_rq_vld=1 in cycle N+1; back-to-back grants SHALL sustain one request per cycle when mc_rq_stall=0.
REQ-012 mc_rq_rtnctl SHALL be {IDW-bit granted index, requester rtnctl}; no requester can alter the ID field.
REQ-013 Response: mc_rs_vld with mc_rs_rtnctl[RTNCTL_WIDTH-1 -: IDW]=k SHALL assert rs_vld[k] one cycle later, all other rs_vld bits 0; rs_pkt carries cmd, scmd, data, low RTNCTL_WIDTH-IDW rtnctl bits, registered.
REQ-014 mc_rs_stall SHALL equal |rs_stall, combinational; responses arriving while stalled SHALL still be forwarded (MC skid honoured, no drop).
REQ-015 Request path and response path SHALL operate independently in the same cycle.

Reset
REQ-016 On i_reset assertion, asynchronously: mc_rq_vld=0, slot empty, rs_vld=0, rs_pkt=0, last_grant=NUM_REQ-1, perf counters 0; rq_stall=all-ones while i_reset high.
REQ-017 Reset mid-stall SHALL discard the held slot; first post-reset grant follows REQ-009.

Configuration
REQ-018 With MC_ARB_PERF_EN defined, perf_grants[i] increments per accepted request of i, perf_stall_cyc per stalled cycle, both wrap at 2^32; without it both outputs are constant 0 and no counter logic exists.

Verification
REQ-019 NUM_REQ=4, all rq_vld=1 continuously, mc_rq_stall=0 -> grant order 0,1,2,3,0,... one per cycle; mc_rq_rtnctl[31:30]=0,1,2,3.
REQ-020 Slot holding vadr 0x1000, mc_rq_stall=1 for 5 cycles -> mc_rq_* stable 5 cycles, all rq_stall=1, perf_stall_cyc=5 (MC_ARB_PERF_EN).
REQ-021 mc_rs_vld with rtnctl=0x8000_0ABC, data 0xDEAD -> next cycle rs_vld=4'b0100, rs_pkt rtnctl=0x0ABC, data 0xDEAD.
REQ-022 rs_stall[1]=1 -> mc_rs_stall=1 same cycle; 2 skid responses for requester 3 still delivered in order.
REQ-023 i_reset pulsed mid-stall, no clk edge -> mc_rq_vld=0 immediately; after release only rq_vld[2]=1 -> requester 2 granted next cycle.
REQ-024 Without MC_ARB_PERF_EN, 100 accepted requests -> perf_grants=0, perf_stall_cyc=0.
